// File: rtl/huffman_decoder_pkg.sv
// Shared definitions for the Huffman decoder and its output stage:
// state encodings, table-entry field positions and field accessors.
package huffman_decoder_pkg;

    localparam int LEN_MSB  = 12;
    localparam int LEN_LSB  = 9;
    localparam int CODE_MSB = 8;
    localparam int MAX_LEN  = 9;
    localparam int NUM_SYM  = 10;
    localparam int ENTRY_W  = LEN_MSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic logic [LEN_MSB-LEN_LSB:0] entry_len(input entry_t e);
        return e[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [CODE_MSB:0] entry_code(input entry_t e);
        return e[CODE_MSB:0];
    endfunction

endpackage

// File: rtl/huffman_match.sv
// Combinational table lookup: finds the lowest-index enabled entry whose
// length equals the candidate length and whose codeword equals the candidate.
module huffman_match
    import huffman_decoder_pkg::*;
(
    input  entry_t [NUM_SYM-1:0] i_table,
    input  logic   [MAX_LEN-1:0] i_cand,
    input  logic   [3:0]         i_len,
    output logic                 o_hit,
    output logic   [3:0]         o_idx
);

    logic [MAX_LEN-1:0] w_mask;

    // Scan from the top index down so the lowest matching index is the one kept.
    always_comb begin
        w_mask = 9'h1ff >> (4'd9 - i_len);
        o_hit  = 1'b0;
        o_idx  = 4'd0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if ((i_len != 4'd0) &&
                (entry_len(i_table[i]) == i_len) &&
                ((entry_code(i_table[i]) & w_mask) == (i_cand & w_mask))) begin
                o_hit = 1'b1;
                o_idx = 4'(i);
            end else begin
                o_hit = o_hit;
                o_idx = o_idx;
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: latches a 10-entry code table on a start event and
// decodes one bit per qualified cycle into symbol indices.
module huffman_decoder
    import huffman_decoder_pkg::*;
(
    input  logic               i_clk_in,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [ENTRY_W-1:0] i_code0,
    input  logic [ENTRY_W-1:0] i_code1,
    input  logic [ENTRY_W-1:0] i_code2,
    input  logic [ENTRY_W-1:0] i_code3,
    input  logic [ENTRY_W-1:0] i_code4,
    input  logic [ENTRY_W-1:0] i_code5,
    input  logic [ENTRY_W-1:0] i_code6,
    input  logic [ENTRY_W-1:0] i_code7,
    input  logic [ENTRY_W-1:0] i_code8,
    input  logic [ENTRY_W-1:0] i_code9,
    input  logic               i_bit_in,
    input  logic               i_bit_valid,
    output logic [3:0]         o_sym,
    output logic               o_sym_valid,
    output logic               o_err,
    output logic [7:0]         o_sym_cnt,
    output logic [1:0]         o_state
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_start_prev;
    entry_t [NUM_SYM-1:0] r_table;
    logic [7:0]           r_acc;
    logic [3:0]           r_cnt;
    logic [3:0]           r_sym;
    logic                 r_sym_valid;
    logic                 r_err;
    logic [7:0]           r_sym_cnt;

    logic                 w_start_evt;
    logic [3:0]           w_len;
    logic                 w_hit;
    logic [3:0]           w_idx;
    logic                 w_last_bit;

    assign w_start_evt = i_start & ~r_start_prev;
    assign w_len       = r_cnt + 4'd1;
    assign w_last_bit  = (r_cnt == 4'(MAX_LEN - 1));

    huffman_match u_match (
        .i_table (r_table),
        .i_cand  ({r_acc, i_bit_in}),
        .i_len   (w_len),
        .o_hit   (w_hit),
        .o_idx   (w_idx)
    );

    // State register.
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a start event wins over bit input in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_start_evt ? ST_LOAD : ST_IDLE;
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_start_evt) begin
                    w_state_nxt = ST_LOAD;
                end else if (i_bit_valid && !w_hit && w_last_bit) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ERR:  w_state_nxt = w_start_evt ? ST_LOAD : ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Table, accumulator and output registers.
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_start_prev <= 1'b0;
            r_table      <= '0;
            r_acc        <= 8'd0;
            r_cnt        <= 4'd0;
            r_sym        <= 4'd0;
            r_sym_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_sym_cnt    <= 8'd0;
        end else begin
            r_start_prev <= i_start;
            r_sym_valid  <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_table   <= {i_code9, i_code8, i_code7, i_code6, i_code5,
                                  i_code4, i_code3, i_code2, i_code1, i_code0};
                    r_acc     <= 8'd0;
                    r_cnt     <= 4'd0;
                    r_sym_cnt <= 8'd0;
                    r_err     <= 1'b0;
                end
                ST_RUN: begin
                    if (!w_start_evt && i_bit_valid) begin
                        if (w_hit) begin
                            r_sym       <= w_idx;
                            r_sym_valid <= 1'b1;
                            r_acc       <= 8'd0;
                            r_cnt       <= 4'd0;
                            if (r_sym_cnt != 8'hff) begin
                                r_sym_cnt <= r_sym_cnt + 8'd1;
                            end else begin
                                r_sym_cnt <= r_sym_cnt;
                            end
                        end else if (w_last_bit) begin
                            r_err <= 1'b1;
                        end else begin
                            r_acc <= {r_acc[6:0], i_bit_in};
                            r_cnt <= w_len;
                        end
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign o_sym       = r_sym;
    assign o_sym_valid = r_sym_valid;
    assign o_err       = r_err;
    assign o_sym_cnt   = r_sym_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed scenarios plus a shuffled
// full-frame stream, compared against a bit-queue prefix-matching model.
module tb_huffman_decoder;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_bit_in = 1'b0;
    logic        i_bit_valid = 1'b0;
    logic [12:0] codes [10];
    logic [3:0]  o_sym;
    logic        o_sym_valid;
    logic        o_err;
    logic [7:0]  o_sym_cnt;
    logic [1:0]  o_state;

    int checks = 0;
    int failures = 0;

    logic [12:0] m_tab [10];
    bit          m_q [$];
    int          m_mode;
    int          m_sym;
    int          m_cnt;
    int          m_err;
    int          hist [10];

    always #5 clk = ~clk;

    huffman_decoder dut (
        .i_clk_in    (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_code0     (codes[0]),
        .i_code1     (codes[1]),
        .i_code2     (codes[2]),
        .i_code3     (codes[3]),
        .i_code4     (codes[4]),
        .i_code5     (codes[5]),
        .i_code6     (codes[6]),
        .i_code7     (codes[7]),
        .i_code8     (codes[8]),
        .i_code9     (codes[9]),
        .i_bit_in    (i_bit_in),
        .i_bit_valid (i_bit_valid),
        .o_sym       (o_sym),
        .o_sym_valid (o_sym_valid),
        .o_err       (o_err),
        .o_sym_cnt   (o_sym_cnt),
        .o_state     (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest table index whose codeword (MSB first) equals the pending bits.
    function automatic int find_match();
        int l;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            l = int'(m_tab[i][12:9]);
            if (l != 0 && l == m_q.size()) begin
                ok = 1'b1;
                for (int j = 0; j < l; j++)
                    if (m_tab[i][l-1-j] != m_q[j]) ok = 1'b0;
                if (ok) return i;
            end
        end
        return -1;
    endfunction

    task automatic check_outs(input string tag, input logic exp_v);
        chk({tag, "_sym_valid"}, 32'(o_sym_valid), 32'(exp_v));
        chk({tag, "_sym"}, 32'(o_sym), 32'(m_sym));
        chk({tag, "_sym_cnt"}, 32'(o_sym_cnt), 32'(m_cnt));
        chk({tag, "_err"}, 32'(o_err), 32'(m_err));
        chk({tag, "_state"}, 32'(o_state), 32'(m_mode));
    endtask

    task automatic send_bit(input bit b);
        int   hit;
        logic exp_v;
        exp_v = 1'b0;
        i_bit_in = b;
        i_bit_valid = 1'b1;
        @(posedge clk);
        #1;
        i_bit_valid = 1'b0;
        if (m_mode == 2) begin
            m_q.push_back(b);
            hit = find_match();
            if (hit >= 0) begin
                m_sym = hit;
                if (m_cnt < 255) m_cnt++;
                m_q.delete();
                exp_v = 1'b1;
            end else if (m_q.size() == 9) begin
                m_mode = 3;
                m_err = 1;
            end
        end
        if (o_sym_valid === 1'b1) hist[o_sym]++;
        check_outs("bit", exp_v);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_outs("gap", 1'b0);
        end
    endtask

    task automatic do_start(input int hold);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_load_state", 32'(o_state), 32'd1);
        chk("start_load_valid", 32'(o_sym_valid), 32'd0);
        for (int i = 0; i < 10; i++) m_tab[i] = codes[i];
        m_q.delete();
        m_mode = 2;
        m_err = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        check_outs("start_run", 1'b0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check_outs("start_hold", 1'b0);
        end
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        m_mode = 0;
        m_sym = 0;
        m_cnt = 0;
        m_err = 0;
        m_q.delete();
        check_outs("reset", 1'b0);
    endtask

    task automatic send_sym(input int s);
        int l;
        l = int'(m_tab[s][12:9]);
        for (int j = l - 1; j >= 0; j--) send_bit(m_tab[s][j]);
    endtask

    initial begin
        int counts [10];
        int stream [$];
        int tmp;
        int r;
        codes = '{13'h0401, 13'h0607, 13'h0601, 13'h0808, 13'h0605,
                  13'h0809, 13'h0a01, 13'h0801, 13'h0a00, 13'h0606};
        counts = '{53, 40, 26, 14, 38, 23, 7, 12, 4, 39};
        for (int i = 0; i < 10; i++) begin
            m_tab[i] = 13'd0;
            hist[i] = 0;
        end

        @(posedge clk);
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);

        do_start(0);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(2);

        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);

        send_bit(1'b0); send_bit(1'b0);
        idle(3);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);

        // Start held high for several cycles yields a single load.
        do_start(3);
        send_bit(1'b0);
        send_bit(1'b1);

        // Start mid-codeword discards the partial code.
        send_bit(1'b1);
        send_bit(1'b1);
        do_start(0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);

        codes[8] = 13'h0000;
        do_start(0);
        for (int k = 0; k < 9; k++) send_bit(1'b0);
        send_bit(1'b1);
        idle(2);
        codes[8] = 13'h0a00;
        do_start(0);
        for (int k = 0; k < 5; k++) send_bit(1'b0);

        send_bit(1'b0);
        send_bit(1'b0);
        do_reset();
        idle(1);
        do_start(0);
        send_bit(1'b0);
        send_bit(1'b1);

        // Shuffled full frame with random inter-bit gaps.
        for (int s = 0; s < 10; s++)
            for (int k = 0; k < counts[s]; k++) stream.push_back(s);
        for (int i = stream.size() - 1; i > 0; i--) begin
            r = int'($urandom_range(0, i));
            tmp = stream[i];
            stream[i] = stream[r];
            stream[r] = tmp;
        end
        do_start(0);
        for (int i = 0; i < 10; i++) hist[i] = 0;
        foreach (stream[i]) begin
            send_sym(stream[i]);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        for (int i = 0; i < 10; i++) chk($sformatf("hist_%0d", i), 32'(hist[i]), 32'(counts[i]));
        chk("final_sym_cnt", 32'(o_sym_cnt), 32'd255);
        chk("final_err", 32'(o_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 Clk_in  input  1  single clock; all state changes on rising edge.
REQ-002 Rst  input  1  reset, synchronous, active-high.
REQ-003 Start  input  1  level; rising edge (sampled) latches code table and begins a frame.
REQ-004 Code0..Code9  input  13 each  table entry: [12:9] code length L (0 = entry disabled, 1..9 valid), [8:0] codeword right-aligned, MSB sent first.
REQ-005 Bit_in  input  1  serial coded bit, from the output stage's Out.
REQ-006 Bit_valid  input  1  Bit_in qualifier, from the output stage's Outt; one bit consumed per cycle while high.
REQ-007 Sym  output  4  decoded symbol index 0..9.
REQ-008 Sym_valid  output  1  one-cycle pulse qualifying Sym.
REQ-009 Err  output  1  sticky; no table match within 9 bits.
REQ-010 Sym_cnt  output  8  symbols decoded since Start, saturating at 255.
REQ-011 State  output  2  IDLE=0, LOAD=1, RUN=2, ERR=3.

Function
REQ-012 Start edge detection: a start event is Start=1 in this cycle and Start=0 in the previous cycle; holding Start high produces only one event.
REQ-013 IDLE: ignore Bit_valid; on a start event go to LOAD.
REQ-014 LOAD: one cycle; latch Code0..Code9 into an internal table, clear accumulator, bit count, Sym_cnt and Err; go to RUN. Later input-table changes have no effect until the next start event.
REQ-015 RUN: for each cycle with Bit_valid=1, the candidate is {acc, Bit_in} with length n+1, where n is the current bit count (0..8).
REQ-016 Match: entry i matches when L_i = n+1 and the low n+1 bits of the codeword equal the candidate; disabled entries never match.
REQ-017 On a match at edge k: Sym=i and Sym_valid=1 during the cycle after edge k (latency 1 cycle from the last bit's sampling edge); clear accumulator and count; increment Sym_cnt.
REQ-018 On no match with n+1 < 9: shift Bit_in into the accumulator LSB and set count to n+1.
REQ-019 On no match with n+1 = 9: set Err=1 and go to ERR; no Sym_valid is produced.
REQ-020 Multiple matches (malformed, non-prefix-free table): the lowest index wins.
REQ-021 Bit_valid=0 in RUN: hold all state; gaps of any length between bits are legal, including mid-codeword.
REQ-022 ERR: ignore bits; hold Err=1; on a start event go to LOAD.
REQ-023 A start event in RUN aborts the frame: any partial codeword is discarded, go to LOAD, no Sym_valid is emitted.
REQ-024 Sym holds its last value between pulses; Sym_valid is never high for two consecutive cycles unless two codewords complete on consecutive cycles (only possible for a 1-bit code).
REQ-025 Sym_cnt saturates at 255 while decoding continues.

Reset
REQ-026 Rst=1 at any edge, including mid-codeword or mid-LOAD, forces: State=IDLE, Sym=0, Sym_valid=0, Err=0, Sym_cnt=0, accumulator=0, count=0, table=0, previous-Start register=0.
REQ-027 Rst has priority over start events and bit input.

Structure
REQ-028 Shared package holds: state encodings, field positions LEN_MSB=12, LEN_LSB=9, CODE_MSB=8, MAX_LEN=9, NUM_SYM=10. The output stage uses the same package.
REQ-029 One sub-module, huffman_match: combinational compare of candidate and length against the table, returning hit and index; instantiated once.

Verification (table: Code0=0x0401, Code1=0x0607, Code2=0x0601, Code3=0x0808, Code4=0x0605, Code5=0x0809, Code6=0x0a01, Code7=0x0801, Code8=0x0a00, Code9=0x0606)
REQ-030 Start, then bits 0,1 on consecutive cycles -> exactly one Sym_valid, Sym=0, one cycle after the second bit; Sym_cnt=1.
REQ-031 Bits 1,1,1,1,1,0 -> Sym=1 then Sym=9; Sym_cnt=2.
REQ-032 Bits 0,0,0,0,0 with Bit_valid low for 3 cycles between bits 2 and 3 -> single Sym=8 pulse; no earlier pulse.
REQ-033 Code8 set to 0x0000 at Start, then nine 0 bits -> Err=1 and State=ERR after the 9th bit, no Sym_valid; a new Start returns to RUN with Err=0.
REQ-034 Rst pulsed after bits 0,0 of a codeword -> all outputs at reset values; bits 0,1 after a new Start -> Sym=0.
REQ-035 Full stream produced by the output stage for the table above, with symbol counts [53,40,26,14,38,23,7,12,4,39] -> per-symbol Sym_valid counts equal the input counts; Sym_cnt=255 (saturated); Err=0.
